// File: rtl/irq_pending_ctrl_if.sv
// Interrupt front-end bus: request/mask lines in, encoder index in, consumer handshake, status out.
// Latency: none (signal bundle only).
// Backpressure: none; the consumer paces service through ack/eoi.
//
// Signals
//   req_in     raw request lines, synchronous to clk
//   mask       1 = line hidden from the encoder (still pends)
//   enc_in     priority encoder output, combinational from pend_out
//   ack        consumer accepts the current interrupt
//   eoi        consumer finished servicing the active interrupt
//   pend_out   visible pending vector, drives the encoder input
//   irq        registered interrupt request to the consumer
//   active_idx index currently in service
//   busy       high while an interrupt is in service
interface irq_pending_ctrl_if #(
   parameter int N    = 8,
   parameter int IDXW = 3
);
   logic [N-1:0]    req_in;
   logic [N-1:0]    mask;
   logic [IDXW-1:0] enc_in;
   logic            ack;
   logic            eoi;
   logic [N-1:0]    pend_out;
   logic            irq;
   logic [IDXW-1:0] active_idx;
   logic            busy;

   // master: the environment (request sources, encoder, consumer)
   modport master (
      output req_in, mask, enc_in, ack, eoi,
      input  pend_out, irq, active_idx, busy
   );

   // slave: the pending controller itself
   modport slave (
      input  req_in, mask, enc_in, ack, eoi,
      output pend_out, irq, active_idx, busy
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: latches request edges, feeds the priority encoder, tracks one in-service index.
// Latency: req rise -> pend same edge, irq one edge later; ack -> busy/irq update at that edge; eoi -> IDLE at that edge.
// Backpressure: none; further requests accumulate in pend while an interrupt is outstanding or in service.
//
// Ports
//   clk        system clock, all state on its rising edge
//   rst        synchronous reset, active-high
//   bus        irq_pending_ctrl_if.slave (req_in, mask, enc_in, ack, eoi -> pend_out, irq, active_idx, busy)
//
// Build option
//   IRQ_LEVEL_MODE_EN  when defined, request lines are level-sensitive (a held line re-pends every
//                      cycle); when undefined, only a 0->1 transition sets the pending bit.
module irq_pending_ctrl #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input logic              clk,
   input logic              rst,
   irq_pending_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    pend;
   logic [N-1:0]    pend_nxt;
   logic            irq;
   logic            irq_nxt;
   logic            busy;
   logic            busy_nxt;
   logic [IDXW-1:0] active_idx;
   logic [IDXW-1:0] active_idx_nxt;
   logic [N-1:0]    rise;
   logic [N-1:0]    clr;
   logic [N-1:0]    vis;
   logic            any;

   // ------------------------------------------------------------------
   // Request capture
   // ------------------------------------------------------------------
`ifdef IRQ_LEVEL_MODE_EN
   // Level mode: every cycle a line is high counts as a new request, so a
   // line still asserted after eoi is immediately pending again.
   assign rise = bus.req_in;
`else
   logic [N-1:0] req_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_prev <= '0;
      end else begin
         req_prev <= bus.req_in;
      end
   end

   // Edge mode: req_prev clears on reset, so a line already high when reset
   // releases is seen as a fresh rising edge.
   assign rise = bus.req_in & ~req_prev;
`endif

   // Masked bits stay pending but are invisible to the encoder.
   assign vis = pend & ~bus.mask;

   // The encoder reports 0 for both "bit 0" and "nothing set", so this is the
   // only validity qualifier for enc_in.
   assign any = |vis;

   // ------------------------------------------------------------------
   // Next-state / next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      irq_nxt        = irq;
      busy_nxt       = busy;
      active_idx_nxt = active_idx;
      clr            = '0;

      case (state)
         IDLE: begin
            if (any) begin
               state_nxt = REQ;
               irq_nxt   = 1'b1;
            end
         end

         REQ: begin
            if (!any) begin
               // Everything visible went away (masked) before the consumer
               // took it; an ack in this cycle has no valid index to capture.
               state_nxt = IDLE;
               irq_nxt   = 1'b0;
            end else if (bus.ack) begin
               state_nxt      = SERVICE;
               irq_nxt        = 1'b0;
               busy_nxt       = 1'b1;
               active_idx_nxt = bus.enc_in;
               clr            = {{(N-1){1'b0}}, 1'b1} << bus.enc_in;
            end
         end

         SERVICE: begin
            // No nesting: irq stays low here regardless of new pending bits.
            if (bus.eoi) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end

         default: begin
            state_nxt = IDLE;
            irq_nxt   = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase

      // A rise on the bit being acknowledged wins over its clear, so the new
      // request is not lost.
      pend_nxt = (pend & ~clr) | rise;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pend       <= '0;
         irq        <= 1'b0;
         busy       <= 1'b0;
         active_idx <= '0;
      end else begin
         state      <= state_nxt;
         pend       <= pend_nxt;
         irq        <= irq_nxt;
         busy       <= busy_nxt;
         active_idx <= active_idx_nxt;
      end
   end

   assign bus.pend_out   = vis;
   assign bus.irq        = irq;
   assign bus.busy       = busy;
   assign bus.active_idx = active_idx;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
module tb_irq_pending_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   irq_pending_ctrl_if #(.N(8), .IDXW(3)) bus ();

   irq_pending_ctrl #(.N(8), .IDXW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Highest set bit wins; 0 when nothing is set.
   function automatic logic [2:0] top_idx(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = i[2:0];
      end
      return r;
   endfunction

   // Stand-in for the external priority encoder.
   always_comb bus.enc_in = top_idx(bus.pend_out);

   // Reference model: an interrupt is either waiting for ack (m_irq),
   // being serviced (m_busy), or neither.
   logic [7:0] m_pend;
   logic [7:0] m_prev;
   logic       m_irq;
   logic       m_busy;
   logic [2:0] m_idx;

`ifdef IRQ_LEVEL_MODE_EN
   localparam bit LEVEL = 1'b1;
`else
   localparam bit LEVEL = 1'b0;
`endif

   task automatic model_edge();
      logic [7:0] rise;
      logic [7:0] vis;
      logic [7:0] clr;
      if (rst) begin
         m_pend = 8'h00; m_prev = 8'h00; m_irq = 1'b0; m_busy = 1'b0; m_idx = 3'd0;
         return;
      end
      rise = LEVEL ? bus.req_in : (bus.req_in & ~m_prev);
      vis  = m_pend & ~bus.mask;
      clr  = 8'h00;
      if (m_busy) begin
         if (bus.eoi) m_busy = 1'b0;
      end else if (m_irq) begin
         if (vis == 8'h00) begin
            m_irq = 1'b0;
         end else if (bus.ack) begin
            m_idx      = top_idx(vis);
            clr[m_idx] = 1'b1;
            m_irq      = 1'b0;
            m_busy     = 1'b1;
         end
      end else if (vis != 8'h00) begin
         m_irq = 1'b1;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = bus.req_in;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: advance model with the inputs as driven, then compare
   // all outputs against it just after the edge.
   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      chk({tag, ".pend_out"},   32'(bus.pend_out),   32'(m_pend & ~bus.mask));
      chk({tag, ".irq"},        32'(bus.irq),        32'(m_irq));
      chk({tag, ".busy"},       32'(bus.busy),       32'(m_busy));
      chk({tag, ".active_idx"}, 32'(bus.active_idx), 32'(m_idx));
   endtask

   initial begin
      checks = 0;
      passes = 0;
      m_pend = 8'h00; m_prev = 8'h00; m_irq = 1'b0; m_busy = 1'b0; m_idx = 3'd0;
      rst = 1'b1;
      bus.req_in = 8'hFF; bus.mask = 8'h00; bus.ack = 1'b0; bus.eoi = 1'b0;

      // Reset held with all lines high
      tick("rst0");
      tick("rst1");
      chk("rst.pend_out", 32'(bus.pend_out), 32'h00);
      chk("rst.irq", 32'(bus.irq), 32'h0);
      chk("rst.busy", 32'(bus.busy), 32'h0);
      chk("rst.active_idx", 32'(bus.active_idx), 32'h0);
      rst = 1'b0;
      tick("rel");
      chk("rel.pend_out", 32'(bus.pend_out), 32'hFF);

      // Clean restart
      rst = 1'b1; bus.req_in = 8'h00;
      tick("rst2");
      rst = 1'b0;
      tick("idle");

      // Single line
      bus.req_in = 8'h02;
      tick("single.set");
      chk("single.irq_lag", 32'(bus.irq), 32'h0);
      tick("single.irq");
      chk("single.irq_on", 32'(bus.irq), 32'h1);
      bus.ack = 1'b1;
      tick("single.ack");
      chk("single.idx", 32'(bus.active_idx), 32'h1);
      chk("single.pend_clr", 32'(bus.pend_out), 32'h00);
      chk("single.busy", 32'(bus.busy), 32'h1);
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("single.eoi");
      chk("single.busy_off", 32'(bus.busy), 32'h0);
      bus.eoi = 1'b0;
      tick("single.post");
      chk("single.irq_off", 32'(bus.irq), 32'h0);
      bus.req_in = 8'h00;
      tick("single.drop");

      // Priority
      bus.req_in = 8'h32;
      tick("prio.set");
      chk("prio.pend", 32'(bus.pend_out), 32'h32);
      tick("prio.irq");
      bus.ack = 1'b1;
      tick("prio.ack1");
      chk("prio.idx1", 32'(bus.active_idx), 32'h5);
      chk("prio.pend1", 32'(bus.pend_out), 32'h12);
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("prio.eoi1");
      bus.eoi = 1'b0;
      tick("prio.rereq");
      chk("prio.irq_again", 32'(bus.irq), 32'h1);
      bus.ack = 1'b1;
      tick("prio.ack2");
      chk("prio.idx2", 32'(bus.active_idx), 32'h4);
      chk("prio.pend2", 32'(bus.pend_out), 32'h02);
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("prio.eoi2");
      bus.eoi = 1'b0;
      tick("prio.rereq2");
      bus.ack = 1'b1;
      tick("prio.ack3");
      chk("prio.idx3", 32'(bus.active_idx), 32'h1);
      bus.ack = 1'b0; bus.eoi = 1'b1; bus.req_in = 8'h00;
      tick("prio.eoi3");
      bus.eoi = 1'b0;
      tick("prio.quiet");

      // Mask
      bus.mask = 8'h01; bus.req_in = 8'h01;
      tick("mask.set");
      chk("mask.hidden", 32'(bus.pend_out), 32'h00);
      tick("mask.wait");
      chk("mask.no_irq", 32'(bus.irq), 32'h0);
      bus.mask = 8'h00;
      tick("mask.unmask");
      chk("mask.visible", 32'(bus.pend_out), 32'h01);
      chk("mask.irq", 32'(bus.irq), 32'h1);
      bus.mask = 8'h01;
      tick("mask.withdraw");
      chk("mask.irq_drop", 32'(bus.irq), 32'h0);
      bus.mask = 8'h00; bus.req_in = 8'h00;
      tick("mask.restore");
      bus.ack = 1'b1;
      tick("mask.ack");
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("mask.eoi");
      bus.eoi = 1'b0;
      tick("mask.quiet");

      // Set wins over clear in the ACK cycle
      bus.req_in = 8'h04;
      tick("setwin.set");
      bus.req_in = 8'h00;
      tick("setwin.irq");
      bus.ack = 1'b1; bus.req_in = 8'h04;
      tick("setwin.ack");
      chk("setwin.pend", 32'(bus.pend_out), 32'h04);
      chk("setwin.busy", 32'(bus.busy), 32'h1);
      chk("setwin.idx", 32'(bus.active_idx), 32'h2);
      bus.ack = 1'b0; bus.eoi = 1'b1; bus.req_in = 8'h00;
      tick("setwin.eoi");
      bus.eoi = 1'b0;
      tick("setwin.rereq");
      bus.ack = 1'b1;
      tick("setwin.ack2");
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("setwin.eoi2");
      bus.eoi = 1'b0;
      tick("setwin.quiet");

      // Held line through ack/eoi: level vs edge behaviour
      bus.req_in = 8'h01;
      tick("hold.set");
      tick("hold.irq");
      bus.ack = 1'b1;
      tick("hold.ack");
      bus.ack = 1'b0; bus.eoi = 1'b1;
      tick("hold.eoi");
      bus.eoi = 1'b0;
      tick("hold.after");
      chk("hold.pend", 32'(bus.pend_out), LEVEL ? 32'h01 : 32'h00);
      chk("hold.irq", 32'(bus.irq), LEVEL ? 32'h1 : 32'h0);
      bus.req_in = 8'h00;

      // Mid-service reset drops everything
      rst = 1'b1;
      tick("midrst");
      rst = 1'b0;
      bus.req_in = 8'hA0;
      tick("midrst.set");
      tick("midrst.irq");
      bus.ack = 1'b1;
      tick("midrst.ack");
      bus.ack = 1'b0; rst = 1'b1;
      tick("midrst.hit");
      chk("midrst.busy", 32'(bus.busy), 32'h0);
      chk("midrst.pend", 32'(bus.pend_out), 32'h00);
      rst = 1'b0; bus.req_in = 8'h00;
      tick("midrst.quiet");

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(63) == 0);
         if ($urandom_range(3) == 0) bus.req_in = 8'($urandom);
         if ($urandom_range(7) == 0) bus.mask = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
         bus.ack = 1'($urandom_range(1));
         bus.eoi = ($urandom_range(3) == 0);
         tick("rand");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt front-end that sits directly upstream of the 8-to-3 priority encoder (pencoder).
- Captures rising edges on 8 request lines into a pending register and drives the masked pending vector into the encoder's `in`.
- Raises `irq` toward the consumer. On `ack`, latches the encoder's `out` as the active index, clears that pending bit, and holds it in service until `eoi`.

Parameters:
- N, 8, number of request lines; width of pending vector and encoder input.
- IDXW, 3, index width; must equal clog2(N); matches encoder `out` width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req_in  input  N  raw interrupt request lines; already synchronous to clk.
- mask  input  N  1 = line masked; bit is kept pending but hidden from the encoder.
- enc_in  input  IDXW  index from the priority encoder's `out`, combinational from pend_out.
- ack  input  1  consumer accepts the current interrupt; sampled only in REQ.
- eoi  input  1  end-of-interrupt; sampled only in SERVICE.
- pend_out  output  N  pend & ~mask; wired to encoder `in`.
- irq  output  1  registered interrupt request.
- active_idx  output  IDXW  index currently in service.
- busy  output  1  high while in SERVICE.

Behaviour:
- Reset (rst=1 at a clock edge): pend=0, req_prev=0, state=IDLE, irq=0, busy=0, active_idx=0. pend_out=0 follows from pend. Reset mid-SERVICE drops the active interrupt and all pending bits without warning.
- Edge detect: req_prev <= req_in every cycle. rise = req_in & ~req_prev.
- Pending update each cycle: pend <= (pend & ~clr) | rise.
  - clr is one-hot at enc_in only in the ACK cycle; otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- Masking:
  - A masked bit still sets pend but is excluded from pend_out.
  - Unmasking a pended bit makes it visible the next cycle it is evaluated.
  - mask never clears pend.
- any = |pend_out. The encoder returns 0 for both "bit 0" and "none", so `any` is the only validity qualifier; enc_in is ignored when any=0.
- FSM states: IDLE, REQ, SERVICE (2-bit encoded).
  - IDLE: if any then state<=REQ, irq<=1.
  - REQ, ack=1 and any=1 (ACK cycle): active_idx<=enc_in, clr pend[enc_in], irq<=0, busy<=1, state<=SERVICE.
  - REQ, ack=0 and any=0 (everything masked before ack): irq<=0, state<=IDLE.
  - REQ, ack=1 and any=0: treated as the any=0 case; no index captured.
  - SERVICE: on eoi, busy<=0, state<=IDLE. New rises still latch into pend; irq stays 0 (no nesting).
- ack outside REQ and eoi outside SERVICE are ignored.
- Latency:
  - req_in rise sampled at edge t → pend bit set at t → irq=1 after edge t+1.
  - ACK at edge t → irq=0 and busy=1 after t.
  - eoi at edge t → IDLE after t; if any, irq=1 after t+1.
- Highest index wins, as determined by the encoder. This block adds no arbitration of its own.

Optional Feature:
- Macro: IRQ_LEVEL_MODE_EN.
- Defined: rise = req_in, i.e. level-sensitive. pend re-sets every cycle a line is high, so a line held high re-requests after eoi. req_prev is unused.
- Undefined: edge-sensitive as above. A line held high produces exactly one pend set.

Test Plan:
- Reset: rst=1 for 2 cycles with req_in=8'hFF → pend_out=0, irq=0, busy=0, active_idx=0. Release rst with req_in held at FF → pend_out=FF after 1 cycle (edge mode: req_prev=0 after reset).
- Single line: req_in 00→02 → irq=1 two cycles later; ack with enc_in=1 → active_idx=1, pend_out=00, busy=1; eoi → busy=0, irq stays 0.
- Priority: req_in 00→32, mask=0 → pend_out=32; ack → active_idx=5, pend_out=12; eoi → irq=1 again; ack → active_idx=4, pend_out=02.
- Mask: req_in rise on bit 0 with mask=01 → pend_out=00, irq=0; mask→00 → pend_out=01, irq=1. In REQ, set mask=01 before ack → irq=0, state IDLE.
- Set-wins: in the ACK cycle for bit 2, drive a new rise on bit 2 → after ack pend_out=04, busy=1, active_idx=2.
- IRQ_LEVEL_MODE_EN defined: hold req_in=01 through ack and eoi → pend_out re-asserts 01 and irq=1 one cycle after eoi. Undefined: pend_out=00, irq=0.
